// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB-Lite encodings, region decode and the fixed
//                register map for the SCSU memory slave.
//  Contents    : htrans_e, hresp_e and region_e enums, ADDR_ID / ADDR_STAT,
//                decode_region() and csr_read() helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        REG_RAM      = 2'd0,
        REG_CSR      = 2'd1,
        REG_UNMAPPED = 2'd2
    } region_e;

    // Byte addresses of the read-only register bank
    localparam logic [13:0] ADDR_ID   = 14'h2000;
    localparam logic [13:0] ADDR_STAT = 14'h2002;

    // haddr is the halfword address, so haddr[12] is byte address bit 13.
    function automatic region_e decode_region(input logic [12:0] haddr);
        if (!haddr[12]) begin
            return REG_RAM;
        end else if (!haddr[11]) begin
            return REG_CSR;
        end
        return REG_UNMAPPED;
    endfunction

    // Register bank read value; unused offsets read as zero.
    function automatic logic [15:0] csr_read(input logic [12:0] haddr,
                                             input logic        last_err,
                                             input logic [15:0] id_value);
        logic [13:0] byte_addr;
        byte_addr = {haddr, 1'b0};
        if (byte_addr == ADDR_ID) begin
            return id_value;
        end else if (byte_addr == ADDR_STAT) begin
            return {15'b0, last_err};
        end
        return 16'h0000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_ram.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_ram
//  Description : Synchronous RAM, 2**AW x DW, one write port and one
//                registered read port sharing one clock.
//  Ports       : clk      in   clock
//                rst      in   async active-high reset (read register only)
//                we_i     in   write enable
//                waddr_i  in   write index
//                wdata_i  in   write data
//                re_i     in   read enable (read register holds otherwise)
//                raddr_i  in   read index
//                rdata_o  out  registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_ram #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Write-first on a same-index collision: a read address phase that
    // overlaps the data phase of a write to the same location sees the
    // new data, which is what makes back-to-back read-after-write coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            if (we_i && (waddr_i == raddr_i)) begin
                rdata_q <= wdata_i;
            end else begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ahb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave
//  Description : 16-bit AHB-Lite memory slave for the SCSU master port.
//                Always selected. Decodes RAM (aliased over 0x0000-0x1FFF),
//                a read-only ID/status bank (0x2000-0x2FFF) and an
//                unmapped region (0x3000-0x3FFF) answering with ERROR.
//  Ports       : clk, rst               clock, async active-high reset
//                scsu_m_ahb_mhtrans     HTRANS
//                scsu_m_ahb_mhsize      HSIZE (ignored, always halfword)
//                scsu_m_ahb_mhwrite     HWRITE
//                scsu_m_ahb_mhaddr      HADDR[13:1]
//                scsu_m_ahb_mhwdata     HWDATA
//                ahb_scsu_m_shrdata     HRDATA
//                ahb_scsu_m_shready     HREADY out
//                ahb_scsu_m_shresp      HRESP
//  Parameters  : RAM_AW (<=12), RD_WAIT (0..7), ID_VALUE
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave
    import ahb_pkg::*;
#(
    parameter int unsigned RAM_AW   = 8,
    parameter int unsigned RD_WAIT  = 0,
    parameter logic [15:0] ID_VALUE = 16'h5C51
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  scsu_m_ahb_mhtrans,
    input  logic [1:0]  scsu_m_ahb_mhsize,
    input  logic        scsu_m_ahb_mhwrite,
    input  logic [12:0] scsu_m_ahb_mhaddr,
    input  logic [15:0] scsu_m_ahb_mhwdata,
    output logic [15:0] ahb_scsu_m_shrdata,
    output logic        ahb_scsu_m_shready,
    output logic [1:0]  ahb_scsu_m_shresp
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    localparam logic [2:0] WAIT_INIT = 3'(RD_WAIT);

    // Response FSM and registered outputs
    logic [1:0]        state_q,   state_d;
    logic [2:0]        wcnt_q,    wcnt_d;
    logic              shready_q, shready_d;
    logic [1:0]        shresp_q,  shresp_d;

    // Address-phase capture for the data phase
    logic              wr_q;
    region_e           region_q;
    logic [RAM_AW-1:0] addr_q;

    // Read-data path
    logic              last_err_q;
    logic [15:0]       csr_rdata_q;
    logic              rd_sel_csr_q;
    logic [15:0]       w_ram_rdata;

    logic              w_accept;
    region_e           w_region;
    logic              w_rd_accept;
    logic              w_ram_re;
    logic              w_csr_re;
    logic              w_ram_we;
    logic              w_stat_hit;
    logic              w_unused;

    // HSIZE is ignored and HTRANS[0] only separates IDLE/BUSY or NONSEQ/SEQ.
    assign w_unused = ^{scsu_m_ahb_mhsize, scsu_m_ahb_mhtrans[0]};

    // An address phase is taken only when the bus is ready.
    assign w_accept    = scsu_m_ahb_mhtrans[1] & shready_q;
    assign w_region    = decode_region(scsu_m_ahb_mhaddr);
    assign w_rd_accept = w_accept & ~scsu_m_ahb_mhwrite;
    assign w_ram_re    = w_rd_accept & (w_region == REG_RAM);
    assign w_csr_re    = w_rd_accept & (w_region == REG_CSR);
    assign w_stat_hit  = ({scsu_m_ahb_mhaddr, 1'b0} == ADDR_STAT);

    // Writes have zero wait states, so the data phase ends on the first
    // edge after the address phase.
    assign w_ram_we = (state_q == ST_DATA) & shready_q & wr_q &
                      (region_q == REG_RAM);

    // ------------------------------------------------------------------
    // State register (registered outputs included)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= 3'd0;
            shready_q <= 1'b1;
            shresp_q  <= HRESP_OKAY;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            shready_q <= shready_d;
            shresp_q  <= shresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (!shready_q) begin
            // Stretched phase: only DATA (read waits) and ERR1 stall.
            case (state_q)
                ST_ERR1: state_d = ST_ERR2;
                ST_DATA: wcnt_d  = wcnt_q - 3'd1;
                default: state_d = ST_IDLE;
            endcase
        end else if (w_accept) begin
            if (w_region == REG_UNMAPPED) begin
                state_d = ST_ERR1;
                wcnt_d  = 3'd0;
            end else begin
                state_d = ST_DATA;
                wcnt_d  = scsu_m_ahb_mhwrite ? 3'd0 : WAIT_INIT;
            end
        end else begin
            state_d = ST_IDLE;
            wcnt_d  = 3'd0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (next values of the registered HREADY/HRESP)
    // ------------------------------------------------------------------
    always_comb begin
        shready_d = 1'b1;
        shresp_d  = HRESP_OKAY;
        if (!shready_q) begin
            case (state_q)
                ST_ERR1: begin
                    shready_d = 1'b1;
                    shresp_d  = HRESP_ERROR;
                end
                // wcnt_q==1 means the wait cycle in progress is the last one.
                ST_DATA: shready_d = (wcnt_q == 3'd1);
                default: shready_d = 1'b1;
            endcase
        end else if (w_accept) begin
            if (w_region == REG_UNMAPPED) begin
                shready_d = 1'b0;
                shresp_d  = HRESP_ERROR;
            end else if (!scsu_m_ahb_mhwrite && (WAIT_INIT != 3'd0)) begin
                shready_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address-phase capture, status flag and register-bank read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q         <= 1'b0;
            region_q     <= REG_RAM;
            addr_q       <= '0;
            last_err_q   <= 1'b0;
            csr_rdata_q  <= 16'h0000;
            rd_sel_csr_q <= 1'b0;
        end else begin
            if (w_accept) begin
                wr_q     <= scsu_m_ahb_mhwrite;
                region_q <= w_region;
                addr_q   <= scsu_m_ahb_mhaddr[RAM_AW-1:0];
            end
            // Read data is fetched in the address phase so that a
            // zero-wait read presents registered data in its data phase.
            if (w_csr_re) begin
                csr_rdata_q <= csr_read(scsu_m_ahb_mhaddr, last_err_q, ID_VALUE);
            end
            if (w_ram_re || w_csr_re) begin
                rd_sel_csr_q <= w_csr_re;
            end
            // Setting and clearing cannot coincide: both need an accepted
            // address phase, and one transfer is either unmapped or CSR.
            if (w_accept && (w_region == REG_UNMAPPED)) begin
                last_err_q <= 1'b1;
            end else if (w_csr_re && w_stat_hit) begin
                last_err_q <= 1'b0;
            end
        end
    end

    ahb_slave_ram #(
        .AW (RAM_AW),
        .DW (16)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_ram_we),
        .waddr_i (addr_q),
        .wdata_i (scsu_m_ahb_mhwdata),
        .re_i    (w_ram_re),
        .raddr_i (scsu_m_ahb_mhaddr[RAM_AW-1:0]),
        .rdata_o (w_ram_rdata)
    );

    // Both sources are flops and hold between reads, so HRDATA keeps the
    // last read value outside read data phases.
    assign ahb_scsu_m_shrdata = rd_sel_csr_q ? csr_rdata_q : w_ram_rdata;
    assign ahb_scsu_m_shready = shready_q;
    assign ahb_scsu_m_shresp  = shresp_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_slave
//  Description : Self-checking bench for ahb_slave. Two instances share the
//                master bus: RD_WAIT=0 and RD_WAIT=2; sel picks the one
//                whose responses drive the master and the scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave;
    import ahb_pkg::*;

    typedef struct {
        logic        err;
        logic        rd;
        logic        chk;
        logic [15:0] data;
        int          waits;
        string       tag;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  htrans;
    logic [1:0]  hsize;
    logic        hwrite;
    logic [12:0] haddr;
    logic [15:0] hwdata;
    logic        sel;

    logic [15:0] rdata0, rdata2;
    logic        rdy0, rdy2;
    logic [1:0]  resp0, resp2;

    logic        w_rdy;
    logic [1:0]  w_resp;
    logic [15:0] w_rdata;
    assign w_rdy   = sel ? rdy2   : rdy0;
    assign w_resp  = sel ? resp2  : resp0;
    assign w_rdata = sel ? rdata2 : rdata0;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    acc_cyc  = 0;
    item_t sb_q[$];

    ahb_slave #(.RAM_AW(8), .RD_WAIT(0), .ID_VALUE(16'h5C51)) u_dut0 (
        .clk                (clk),
        .rst                (rst),
        .scsu_m_ahb_mhtrans (htrans),
        .scsu_m_ahb_mhsize  (hsize),
        .scsu_m_ahb_mhwrite (hwrite),
        .scsu_m_ahb_mhaddr  (haddr),
        .scsu_m_ahb_mhwdata (hwdata),
        .ahb_scsu_m_shrdata (rdata0),
        .ahb_scsu_m_shready (rdy0),
        .ahb_scsu_m_shresp  (resp0)
    );

    ahb_slave #(.RAM_AW(8), .RD_WAIT(2), .ID_VALUE(16'h5C51)) u_dut2 (
        .clk                (clk),
        .rst                (rst),
        .scsu_m_ahb_mhtrans (htrans),
        .scsu_m_ahb_mhsize  (hsize),
        .scsu_m_ahb_mhwrite (hwrite),
        .scsu_m_ahb_mhaddr  (haddr),
        .scsu_m_ahb_mhwdata (hwdata),
        .ahb_scsu_m_shrdata (rdata2),
        .ahb_scsu_m_shready (rdy2),
        .ahb_scsu_m_shresp  (resp2)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_value(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        htrans = HTRANS_IDLE;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one address phase, holds it until HREADY, pushes the expected
    // response and then drives write data for the data phase.
    task automatic xfer(input logic wr, input logic [13:0] baddr,
                        input logic [15:0] wd, input logic [15:0] exp_rd,
                        input logic chk, input string tag);
        item_t it;
        it.err   = (baddr[13:12] == 2'b11);
        it.rd    = ~wr;
        it.chk   = chk & ~wr;
        it.data  = exp_rd;
        it.waits = it.err ? 1 : (wr ? 0 : (sel ? 2 : 0));
        it.tag   = tag;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        haddr  = baddr[13:1];
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (w_rdy) break;
        end
        if (!w_rdy) check_value({tag, "_hready_timeout"}, {31'b0, w_rdy}, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        sb_q.push_back(it);
        if (wr) hwdata = wd;
    endtask

    // Data-phase monitor: follows accepted address phases and compares
    // each completed data phase against the head of the scoreboard.
    initial begin
        logic  dp_active;
        int    wcnt;
        item_t cur;
        dp_active = 1'b0;
        wcnt      = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dp_active = 1'b0;
                wcnt      = 0;
                sb_q.delete();
            end else begin
                if (dp_active) begin
                    if (sb_q.size() == 0) begin
                        check_value("sb_underflow", sb_q.size(), 32'd1);
                        dp_active = 1'b0;
                    end else begin
                        cur = sb_q[0];
                        if (!w_rdy) begin
                            wcnt++;
                            check_value({cur.tag, "_wait_resp"}, {30'b0, w_resp},
                                        cur.err ? 32'd1 : 32'd0);
                            if (wcnt > 16) begin
                                check_value({cur.tag, "_phase_timeout"}, wcnt, cur.waits);
                                void'(sb_q.pop_front());
                                dp_active = 1'b0;
                                wcnt      = 0;
                            end
                        end else begin
                            void'(sb_q.pop_front());
                            check_value({cur.tag, "_resp"}, {30'b0, w_resp},
                                        cur.err ? 32'd1 : 32'd0);
                            check_value({cur.tag, "_waits"}, wcnt, cur.waits);
                            if (cur.chk)
                                check_value({cur.tag, "_rdata"}, {16'b0, w_rdata},
                                            {16'b0, cur.data});
                            dp_active = 1'b0;
                            wcnt      = 0;
                        end
                    end
                end
                if (w_rdy && htrans[1]) dp_active = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        htrans = HTRANS_IDLE;
        hsize  = 2'b01;
        hwrite = 1'b0;
        haddr  = '0;
        hwdata = '0;
        sel    = 1'b0;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_ready0", {31'b0, rdy0}, 32'd1);
        check_value("rst_resp0",  {30'b0, resp0}, 32'd0);
        check_value("rst_rdata0", {16'b0, rdata0}, 32'd0);
        check_value("rst_ready2", {31'b0, rdy2}, 32'd1);
        rst = 1'b0;
        idle(2);

        // Write / read-back, including back-to-back read-after-write
        xfer(1'b1, 14'h0000, 16'h1234, 16'h0, 1'b0, "wr_0000");
        xfer(1'b1, 14'h0002, 16'hA0A0, 16'h0, 1'b0, "wr_0002");
        xfer(1'b1, 14'h0004, 16'h0A0A, 16'h0, 1'b0, "wr_0004");
        xfer(1'b1, 14'h0010, 16'h5A5A, 16'h0, 1'b0, "wr_0010");
        xfer(1'b1, 14'h0008, 16'hBEEF, 16'h0, 1'b0, "wr_0008");
        xfer(1'b0, 14'h0008, 16'h0,    16'hBEEF, 1'b1, "raw_0008");
        idle(2);
        hsize = 2'b11;
        xfer(1'b0, 14'h0000, 16'h0, 16'h1234, 1'b1, "rd_0000");
        idle(1);
        xfer(1'b0, 14'h0002, 16'h0, 16'hA0A0, 1'b1, "rd_0002");
        idle(1);
        xfer(1'b0, 14'h0004, 16'h0, 16'h0A0A, 1'b1, "rd_0004");
        idle(2);
        hsize = 2'b01;

        // Back-to-back reads, one per cycle
        xfer(1'b0, 14'h0000, 16'h0, 16'h1234, 1'b1, "b2b_0000");
        t0 = acc_cyc;
        xfer(1'b0, 14'h0002, 16'h0, 16'hA0A0, 1'b1, "b2b_0002");
        xfer(1'b0, 14'h0004, 16'h0, 16'h0A0A, 1'b1, "b2b_0004");
        xfer(1'b0, 14'h0006, 16'h0, 16'h0,    1'b0, "b2b_0006");
        check_value("b2b_span", acc_cyc - t0, 32'd3);
        idle(2);

        // Register bank and RAM aliasing
        xfer(1'b0, 14'h2000, 16'h0, 16'h5C51, 1'b1, "rd_id");
        xfer(1'b0, 14'h200C, 16'h0, 16'h0000, 1'b1, "rd_200c");
        xfer(1'b0, 14'h0200, 16'h0, 16'h1234, 1'b1, "rd_alias");
        xfer(1'b1, 14'h2000, 16'hFFFF, 16'h0, 1'b0, "wr_id");
        xfer(1'b0, 14'h2000, 16'h0, 16'h5C51, 1'b1, "rd_id2");
        idle(2);

        // Unmapped region and the sticky error flag
        xfer(1'b1, 14'h3010, 16'hABCD, 16'h0, 1'b0, "err_wr_3010");
        xfer(1'b1, 14'h3012, 16'hA00A, 16'h0, 1'b0, "err_wr_3012");
        xfer(1'b0, 14'h2002, 16'h0, 16'h0001, 1'b1, "stat1");
        xfer(1'b0, 14'h2002, 16'h0, 16'h0000, 1'b1, "stat2");
        xfer(1'b0, 14'h0010, 16'h0, 16'h5A5A, 1'b1, "ram_kept");
        xfer(1'b0, 14'h3000, 16'h0, 16'h0,    1'b0, "err_rd_3000");
        xfer(1'b0, 14'h2002, 16'h0, 16'h0001, 1'b1, "stat3");
        idle(6);

        // RD_WAIT=2 instance: pipelined read held through the wait states
        sel = 1'b1;
        idle(2);
        xfer(1'b0, 14'h0000, 16'h0, 16'h1234, 1'b1, "w2_0000");
        xfer(1'b0, 14'h0002, 16'h0, 16'hA0A0, 1'b1, "w2_0002");
        idle(6);
        sel = 1'b0;
        idle(6);

        // Reset during a write data phase
        xfer(1'b1, 14'h0000, 16'hFFFF, 16'h0, 1'b0, "wr_abort");
        rst    = 1'b1;
        htrans = HTRANS_IDLE;
        #1;
        check_value("arst_ready", {31'b0, rdy0}, 32'd1);
        check_value("arst_resp",  {30'b0, resp0}, 32'd0);
        check_value("arst_rdata", {16'b0, rdata0}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        xfer(1'b0, 14'h0000, 16'h0, 16'h1234, 1'b1, "rd_after_abort");
        idle(3);
        check_value("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
